// File: rtl/writeback_stage.sv
// Final pipeline stage: aligns/extends load data, holds one retiring result in a
// registered slot, drives the register-file write port and a forwarding tap, and
// counts committed non-faulting instructions.
module writeback_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic             in_is_load,
   input  logic [2:0]       in_funct3,
   input  logic [1:0]       in_addr_lo,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_load_word,
   input  logic             halt,
   output logic [XLEN-1:0]  rd,
   output logic             wr_en,
   output logic [XLEN-1:0]  rd_value,
   output logic             fwd_valid,
   output logic [4:0]       fwd_rd,
   output logic [XLEN-1:0]  fwd_value,
   output logic             misalign_err,
   output logic [CNT_W-1:0] instret
);

   // Slot state
   logic             occ_q, occ_d;
   logic [4:0]       s_rd_q, s_rd_d;
   logic             s_we_q, s_we_d;
   logic [XLEN-1:0]  s_val_q, s_val_d;
   logic             s_err_q, s_err_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic             accept;
   logic             commit;
   logic             slot_ok;

   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [XLEN-1:0]  ld_val;
   logic             ld_err;

   // Load alignment and extension ahead of the slot, so the slot holds final data
   always_comb begin
      ld_byte = 8'h00;
      unique case (in_addr_lo)
         2'd0: ld_byte = in_load_word[7:0];
         2'd1: ld_byte = in_load_word[15:8];
         2'd2: ld_byte = in_load_word[23:16];
         2'd3: ld_byte = in_load_word[31:24];
         default: ld_byte = 8'h00;
      endcase
      ld_half = in_addr_lo[1] ? in_load_word[31:16] : in_load_word[15:0];
      ld_val  = '0;
      ld_err  = 1'b0;
      case (in_funct3)
         3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001: begin
            ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            ld_err = in_addr_lo[0];
         end
         3'b010: begin
            ld_val = in_load_word;
            ld_err = (in_addr_lo != 2'd0);
         end
         3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101: begin
            ld_val = {{(XLEN-16){1'b0}}, ld_half};
            ld_err = in_addr_lo[0];
         end
         default: ld_err = 1'b1;
      endcase
   end

   // Handshake: a committing slot frees itself for a same-cycle accept
   always_comb begin
      in_ready = !occ_q || !halt;
      accept   = in_valid && in_ready;
      commit   = occ_q && !halt;
      slot_ok  = s_we_q && (s_rd_q != 5'd0) && !s_err_q;
   end

   // Next-state for slot and retired-instruction counter
   always_comb begin
      occ_d     = occ_q;
      s_rd_d    = s_rd_q;
      s_we_d    = s_we_q;
      s_val_d   = s_val_q;
      s_err_d   = s_err_q;
      instret_d = instret_q;
      if (commit && !s_err_q) begin
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept) begin
         occ_d   = 1'b1;
         s_rd_d  = in_rd;
         s_we_d  = in_reg_write;
         s_val_d = in_is_load ? ld_val : in_alu_result;
         s_err_d = in_is_load && ld_err;
      end else if (commit) begin
         occ_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q     <= 1'b0;
         s_rd_q    <= 5'd0;
         s_we_q    <= 1'b0;
         s_val_q   <= '0;
         s_err_q   <= 1'b0;
         instret_q <= '0;
      end else begin
         occ_q     <= occ_d;
         s_rd_q    <= s_rd_d;
         s_we_q    <= s_we_d;
         s_val_q   <= s_val_d;
         s_err_q   <= s_err_d;
         instret_q <= instret_d;
      end
   end

   // Register-file port, forwarding tap and fault pulse
   always_comb begin
      wr_en        = commit && slot_ok;
      rd           = {{(XLEN-5){1'b0}}, s_rd_q};
      rd_value     = s_val_q;
      misalign_err = commit && s_err_q;
      fwd_valid    = occ_q && slot_ok;
      fwd_rd       = s_rd_q;
      fwd_value    = s_val_q;
      instret      = instret_q;
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic, checked
// by a scoreboard monitor against a behavioural model of the slot.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rd = '0;
   logic        in_reg_write = 1'b0;
   logic        in_is_load = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [1:0]  in_addr_lo = '0;
   logic [31:0] in_alu_result = '0;
   logic [31:0] in_load_word = '0;
   logic        halt = 1'b0;
   logic [31:0] rd;
   logic        wr_en;
   logic [31:0] rd_value;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_value;
   logic        misalign_err;
   logic [63:0] instret;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
      .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
      .in_load_word(in_load_word), .halt(halt), .rd(rd), .wr_en(wr_en),
      .rd_value(rd_value), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
      .fwd_value(fwd_value), .misalign_err(misalign_err), .instret(instret)
   );

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] alu;
      logic [31:0] word;
   } stim_t;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] val;
      logic        err;
   } exp_t;

   exp_t pend[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   // Reference: result of one offered instruction, from the load-type rules
   function automatic exp_t ref_model(input stim_t s);
      exp_t e;
      int unsigned sh;
      int unsigned b;
      int unsigned h;
      e.valid = s.valid;
      e.rd    = s.rd;
      e.we    = s.we;
      e.val   = s.alu;
      e.err   = 1'b0;
      if (s.ld) begin
         sh = 8 * int'(s.lo);
         b  = (s.word >> sh) & 32'hFF;
         h  = (s.word >> sh) & 32'hFFFF;
         case (s.f3)
            3'd0: e.val = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4: e.val = b;
            3'd1: e.val = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5: e.val = h;
            3'd2: e.val = s.word;
            default: e.val = 32'h0;
         endcase
         if ((s.f3 == 3'd1 || s.f3 == 3'd5) && (s.lo % 2 == 1)) e.err = 1'b1;
         if (s.f3 == 3'd2 && s.lo != 2'd0) e.err = 1'b1;
         if (s.f3 == 3'd3 || s.f3 == 3'd6 || s.f3 == 3'd7) e.err = 1'b1;
      end
      return e;
   endfunction

   function automatic stim_t mk(input logic v, input logic [4:0] r, input logic we,
                                input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                                input logic [31:0] alu, input logic [31:0] word);
      stim_t s;
      s.valid = v; s.rd = r; s.we = we; s.ld = ld; s.f3 = f3; s.lo = lo;
      s.alu = alu; s.word = word;
      return s;
   endfunction

   // One cycle of stimulus; the expected result is queued as it is issued
   task automatic drive(input stim_t s, input logic h, input logic r);
      @(posedge clk);
      #1;
      in_valid      = s.valid;
      in_rd         = s.rd;
      in_reg_write  = s.we;
      in_is_load    = s.ld;
      in_funct3     = s.f3;
      in_addr_lo    = s.lo;
      in_alu_result = s.alu;
      in_load_word  = s.word;
      halt          = h;
      rst_n         = r;
      pend.push_back(ref_model(s));
   endtask

   // Monitor: compares outputs to the modelled slot, then advances the model
   initial begin : monitor
      bit          m_occ;
      exp_t        m_slot;
      exp_t        p;
      logic [63:0] m_cnt;
      bit          cmt;
      bit          rdy;
      bit          ok;
      m_occ = 0;
      m_cnt = '0;
      m_slot = '{valid: 1'b0, rd: 5'd0, we: 1'b0, val: 32'h0, err: 1'b0};
      @(posedge clk);
      forever begin
         @(negedge clk);
         rdy = !m_occ || !halt;
         cmt = m_occ && !halt;
         ok  = m_slot.we && (m_slot.rd != 5'd0) && !m_slot.err;
         check("mon_in_ready", 64'(in_ready), 64'(rdy));
         check("mon_fwd_valid", 64'(fwd_valid), 64'(m_occ && ok));
         if (m_occ && ok) begin
            check("mon_fwd_rd", 64'(fwd_rd), 64'(m_slot.rd));
            check("mon_fwd_value", 64'(fwd_value), 64'(m_slot.val));
         end
         check("mon_wr_en", 64'(wr_en), 64'(cmt && ok));
         if (cmt && ok) begin
            check("mon_rd", 64'(rd), 64'(m_slot.rd));
            check("mon_rd_value", 64'(rd_value), 64'(m_slot.val));
         end
         check("mon_misalign", 64'(misalign_err), 64'(cmt && m_slot.err));
         check("mon_instret", instret, m_cnt);
         p.valid = 1'b0;
         if (pend.size() > 0) p = pend.pop_front();
         if (!rst_n) begin
            m_occ = 0;
            m_cnt = '0;
            m_slot = '{valid: 1'b0, rd: 5'd0, we: 1'b0, val: 32'h0, err: 1'b0};
         end else begin
            if (cmt && !m_slot.err) m_cnt = m_cnt + 64'd1;
            if (p.valid && rdy) begin
               m_slot = p;
               m_occ  = 1;
            end else if (cmt) begin
               m_occ = 0;
            end
         end
      end
   end

   stim_t idle;
   stim_t s;

   initial begin : stimulus
      idle = mk(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0);
      repeat (3) drive(idle, 1'b0, 1'b0);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_rd", 64'(rd), 64'd0);
      check("rst_rd_value", 64'(rd_value), 64'd0);
      check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("rst_misalign", 64'(misalign_err), 64'd0);
      check("rst_instret", instret, 64'd0);

      // LB, byte 2 of 0x12F45678 = 0xF4, sign-extended
      drive(mk(1'b1, 5'd5, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, 32'h12F45678), 1'b0, 1'b1);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("lb_wr_en", 64'(wr_en), 64'd1);
      check("lb_rd", 64'(rd), 64'd5);
      check("lb_value", 64'(rd_value), 64'hFFFFFFF4);
      check("lb_instret_before", instret, 64'd0);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("lb_instret_after", instret, 64'd1);

      drive(mk(1'b1, 5'd7, 1'b1, 1'b1, 3'd5, 2'd2, 32'h0, 32'hBEEF0001), 1'b0, 1'b1);
      drive(mk(1'b1, 5'd7, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'hBEEF0001), 1'b0, 1'b1);
      @(negedge clk);
      check("lhu_value", 64'(rd_value), 64'h0000BEEF);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("lh_value", 64'(rd_value), 64'hFFFFBEEF);

      // Misaligned LW: one-cycle fault pulse, no write, not counted
      drive(mk(1'b1, 5'd9, 1'b1, 1'b1, 3'd2, 2'd1, 32'h0, 32'h11223344), 1'b0, 1'b1);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("lw_misalign", 64'(misalign_err), 64'd1);
      check("lw_wr_en", 64'(wr_en), 64'd0);
      check("lw_fwd_valid", 64'(fwd_valid), 64'd0);
      check("lw_instret", instret, 64'd3);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("lw_misalign_gone", 64'(misalign_err), 64'd0);
      check("lw_instret_after", instret, 64'd3);

      // Write to x0: no strobe but still counted
      drive(mk(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0), 1'b0, 1'b1);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("x0_wr_en", 64'(wr_en), 64'd0);
      check("x0_fwd_valid", 64'(fwd_valid), 64'd0);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("x0_instret", instret, 64'd4);

      // Halt for three cycles with A held and B waiting
      drive(mk(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hAAAA0001, 32'h0), 1'b0, 1'b1);
      s = mk(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'hBBBB0002, 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(s, 1'b1, 1'b1);
         @(negedge clk);
         check("halt_in_ready", 64'(in_ready), 64'd0);
         check("halt_wr_en", 64'(wr_en), 64'd0);
         check("halt_fwd_rd", 64'(fwd_rd), 64'd1);
         check("halt_fwd_value", 64'(fwd_value), 64'hAAAA0001);
      end
      drive(s, 1'b0, 1'b1);
      @(negedge clk);
      check("rel_a_wr_en", 64'(wr_en), 64'd1);
      check("rel_a_rd", 64'(rd), 64'd1);
      check("rel_a_value", 64'(rd_value), 64'hAAAA0001);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("rel_b_wr_en", 64'(wr_en), 64'd1);
      check("rel_b_rd", 64'(rd), 64'd2);
      check("rel_b_value", 64'(rd_value), 64'hBBBB0002);

      // Reset while an entry is held discards it
      drive(mk(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'h12345678, 32'h0), 1'b0, 1'b1);
      drive(idle, 1'b1, 1'b0);
      drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      check("mrst_in_ready", 64'(in_ready), 64'd1);
      check("mrst_wr_en", 64'(wr_en), 64'd0);
      check("mrst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("mrst_instret", instret, 64'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s = mk(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                32'($urandom), 32'($urandom));
         drive(s, ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
               ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
      end
      repeat (4) drive(idle, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts retiring results from the memory stage, aligns and extends load data, and drives the register-file write port (rd, wr_en, rd_value).
- Holds one result in a registered slot. Supports back-pressure via a halt input.
- Provides a forwarding tap to decode/execute and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  memory stage presents a result
- in_ready  output  1  stage accepts the result this cycle
- in_rd  input  5  destination register index
- in_reg_write  input  1  instruction writes a register
- in_is_load  input  1  select load path instead of ALU result
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  input  2  low bits of the load address
- in_alu_result  input  32  ALU/CSR/PC+4 result
- in_load_word  input  32  raw aligned 32-bit word from data memory
- halt  input  1  freeze commit (debug/stall)
- rd  output  32  register-file write index; bits [31:5] are always 0
- wr_en  output  1  register-file write strobe
- rd_value  output  32  register-file write data
- fwd_valid  output  1  slot holds a forwardable result
- fwd_rd  output  5  forwarding index
- fwd_value  output  32  forwarding data
- misalign_err  output  1  one-cycle pulse when a faulting entry commits
- instret  output  64  count of committed non-faulting entries

Behaviour:
- Slot state: occ, s_rd, s_we, s_val, s_err.
  - accept = in_valid && in_ready.
  - commit = occ && !halt.
  - in_ready = !occ || !halt, so a new entry is accepted in the same cycle the old one commits.
- Latency: accepted at edge N, visible on wr_en during cycle N+1, written by the register file at edge N+1. Sustained throughput is 1/cycle when halt=0.
- Load alignment is done before the slot register; the slot stores the final value.
  - Byte selected by addr_lo (0 = bits 7:0 … 3 = bits 31:24).
  - Halfword: addr_lo=0 gives bits 15:0, addr_lo=2 gives bits 31:16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Fault (s_err=1):
  - LH/LHU with addr_lo odd.
  - LW with addr_lo≠0.
  - in_is_load with funct3 ∈ {011,110,111}.
  - Non-load entries never fault.
- Outputs:
  - wr_en = commit && s_we && s_rd≠0 && !s_err.
  - rd = {27'b0, s_rd}.
  - rd_value = s_val.
- Writes to x0 are never issued (wr_en=0). The entry still commits and counts toward instret.
- misalign_err = commit && s_err. A faulting entry never writes and is not counted.
- instret increments by 1 per commit with !s_err and wraps at 2^64−1 → 0.
- Forwarding:
  - fwd_valid = occ && s_we && s_rd≠0 && !s_err, independent of halt.
  - fwd_rd = s_rd; fwd_value = s_val.
- Simultaneous commit+accept: the slot is overwritten with the new entry and occ stays 1.
- Commit without accept: occ ← 0.
- halt=1 with occ=1: the slot is frozen, in_ready=0, all commit-qualified outputs are 0, and fwd_* remain valid.
- Reset (rst_n=0 at an edge):
  - occ=0, s_rd=0, s_we=0, s_val=0, s_err=0, instret=0.
  - Resulting outputs: in_ready=1, wr_en=0, rd=0, rd_value=0, fwd_valid=0, misalign_err=0.
  - A reset mid-operation discards any held entry without writing. in_valid is ignored while rst_n=0.

Test Plan:
- LB with addr_lo=2, load_word=0x12F45678, rd=5, no halt → the cycle after accept: wr_en=1, rd=5, rd_value=0xFFFFFFF4; instret 0→1.
- LHU with addr_lo=2, load_word=0xBEEF0001, rd=7 → rd_value=0x0000BEEF. LH with the same inputs → 0xFFFFBEEF.
- LW with addr_lo=1, rd=9 → wr_en=0, misalign_err=1 for exactly one cycle, instret unchanged, fwd_valid=0.
- ALU result 0xDEADBEEF to rd=0 → wr_en=0, instret increments, fwd_valid=0.
- Back-to-back ALU results A→x1 and B→x2 with halt=1 for 3 cycles after A is accepted:
  - in_ready=0 for those 3 cycles, wr_en=0, fwd_rd=1 and fwd_value=A throughout.
  - After release, A and B are written on consecutive cycles with no loss.
- Accept an entry, then assert rst_n=0 for one edge before commit → no write occurs, instret=0, in_ready=1 on the following cycle.
